pc_fetch_sequencer: RTL and testbench

- Owns the 11-bit program counter and sequences one instruction at a time: fetch, issue, resolve.
- Drives the next-PC mux select (pc_src, 2'b00 PC+1, 2'b01 beq, 2'b10 jrra, 2'b11 jal) and the PC value the mux adds to.
- Loads the mux result back into PC when the instruction resolves.
- Sits between instruction memory, decode/control and the next-PC mux.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the PC fetch sequencer: state encoding,
// next-PC mux select codes and default bus widths.
package pc_seq_pkg;

    localparam int unsigned PC_W     = 11;
    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned RETIRE_W = 16;
    localparam int unsigned TIMEOUT  = 15;

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_ISSUE   = 2'b01,
        S_RESOLVE = 2'b10,
        S_HALTED  = 2'b11
    } state_e;

    localparam logic [1:0] PCSRC_INC  = 2'b00;
    localparam logic [1:0] PCSRC_BEQ  = 2'b01;
    localparam logic [1:0] PCSRC_JRRA = 2'b10;
    localparam logic [1:0] PCSRC_JAL  = 2'b11;

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Owns the program counter and walks each instruction through fetch, issue
// and resolve. Define FETCH_TIMEOUT_EN to halt with fetch_err on a stuck fetch.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_W-1:0]     pc,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                resolve_valid,
    input  logic [1:0]          resolve_src,
    input  logic                halt,
    input  logic [PC_W-1:0]     next_pc,
    output logic [1:0]          pc_src,
    output logic                pc_we,
    output logic [RETIRE_W-1:0] retire_cnt,
    output logic                halted,
    output logic                fetch_err
);

    state_e state, state_nxt;
    logic   active;
    logic   fetch_hit;
    logic   timeout_hit;

    // Low for the first cycle out of reset so a stale ack is never latched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        fetch_hit = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PCSRC_INC;
        case (state)
            S_FETCH: begin
                if (active) begin
                    if (imem_ack) begin
                        fetch_hit = 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (timeout_hit) begin
                        state_nxt = S_HALTED;
                    end
                end
            end
            S_ISSUE: begin
                if (instr_ready) state_nxt = S_RESOLVE;
            end
            S_RESOLVE: begin
                pc_src = resolve_src;
                if (resolve_valid) begin
                    pc_we     = 1'b1;
                    state_nxt = halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // PC is loaded verbatim from the mux; wrap-around is the mux's job.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= '0;
            retire_cnt <= '0;
        end else begin
            if (fetch_hit) instr <= imem_rdata;
            if (pc_we) begin
                pc         <= next_pc;
                retire_cnt <= retire_cnt + RETIRE_W'(1);
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;

    assign timeout_hit = (state == S_FETCH) && active && !imem_ack &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // Counts unanswered request cycles; zero whenever outside FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state == S_FETCH) && active && !imem_ack) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                                          wait_cnt <= '0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    assign imem_req    = active && (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALTED);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized bench for pc_fetch_sequencer against a transaction-level model
// of expected PC, retire count and latched instruction.
module tb_pc_fetch_sequencer;

    localparam int unsigned TO_CYCLES = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] pc;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        resolve_valid;
    logic [1:0]  resolve_src;
    logic        halt;
    logic [10:0] next_pc;
    logic [1:0]  pc_src;
    logic        pc_we;
    logic [15:0] retire_cnt;
    logic        halted;
    logic        fetch_err;

    int checks = 0;
    int passes = 0;

    logic [10:0] exp_pc;
    logic [15:0] exp_ret;

    pc_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .resolve_valid(resolve_valid), .resolve_src(resolve_src),
        .halt(halt), .next_pc(next_pc), .pc_src(pc_src), .pc_we(pc_we),
        .retire_cnt(retire_cnt), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; resolve_valid = 1'b0; halt = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        exp_pc = 11'h000; exp_ret = 16'h0000;
    endtask

    // Drives one instruction through fetch/issue/resolve with noise on ignored inputs.
    task automatic run_instr(input logic [15:0] rdata, input int ack_dly, input int rdy_dly,
                             input int res_dly, input logic [1:0] src, input logic [10:0] npc,
                             input logic hlt,
                             output logic [10:0] o_addr, output logic o_req,
                             output logic [15:0] o_instr, output logic o_issue_ok,
                             output logic o_quiet, output logic [1:0] o_src, output logic o_we);
        o_addr = imem_addr; o_req = imem_req; o_issue_ok = 1'b1; o_quiet = 1'b1;
        resolve_src = src; next_pc = npc;
        for (int i = 0; i < ack_dly; i++) begin
            imem_ack = 1'b0; instr_ready = 1'($urandom); resolve_valid = 1'($urandom); halt = 1'($urandom);
            #1;
            if (pc_we !== 1'b0 || pc_src !== 2'b00 || imem_req !== 1'b1 || instr_valid !== 1'b0) o_quiet = 1'b0;
            step();
        end
        imem_rdata = rdata; imem_ack = 1'b1;
        instr_ready = 1'($urandom); resolve_valid = 1'($urandom); halt = 1'($urandom);
        step();
        imem_ack = 1'b0; imem_rdata = 16'($urandom);
        o_instr = instr;
        for (int i = 0; i < rdy_dly; i++) begin
            instr_ready = 1'b0; imem_ack = 1'($urandom); resolve_valid = 1'($urandom); halt = 1'($urandom);
            #1;
            if (instr_valid !== 1'b1 || instr !== o_instr || imem_req !== 1'b0) o_issue_ok = 1'b0;
            if (pc_we !== 1'b0 || pc_src !== 2'b00) o_quiet = 1'b0;
            step();
        end
        instr_ready = 1'b1; imem_ack = 1'($urandom); resolve_valid = 1'($urandom); halt = 1'($urandom);
        #1;
        if (instr_valid !== 1'b1 || instr !== o_instr) o_issue_ok = 1'b0;
        if (pc_we !== 1'b0 || pc_src !== 2'b00) o_quiet = 1'b0;
        step();
        for (int i = 0; i < res_dly; i++) begin
            resolve_valid = 1'b0; halt = 1'($urandom); imem_ack = 1'($urandom); instr_ready = 1'($urandom);
            #1;
            if (pc_we !== 1'b0 || pc_src !== src || instr_valid !== 1'b0 || imem_req !== 1'b0) o_quiet = 1'b0;
            step();
        end
        resolve_valid = 1'b1; halt = hlt; imem_ack = 1'($urandom); instr_ready = 1'($urandom);
        #1;
        o_src = pc_src; o_we = pc_we;
        step();
        resolve_valid = 1'b0; halt = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1; resolve_valid = 1'b1; halt = 1'b1;
        resolve_src = 2'b11; next_pc = 11'h155; imem_rdata = 16'hFFFF;
        step(); step();
        checks++; if (pc !== 11'h000) $display("FAIL reset_pc: got %h exp 000", pc); else passes++;
        checks++; if (instr !== 16'h0000) $display("FAIL reset_instr: got %h exp 0000", instr); else passes++;
        checks++; if (retire_cnt !== 16'h0000) $display("FAIL reset_retire: got %h exp 0000", retire_cnt); else passes++;
        checks++; if ({imem_req, instr_valid, halted, fetch_err, pc_we} !== 5'b0)
            $display("FAIL reset_outs: got req/val/hlt/err/we=%b exp 00000", {imem_req, instr_valid, halted, fetch_err, pc_we}); else passes++;
        checks++; if (pc_src !== 2'b00) $display("FAIL reset_pc_src: got %b exp 00", pc_src); else passes++;
        imem_ack = 1'b0; instr_ready = 1'b0; resolve_valid = 1'b0; halt = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL reset_req_early: got %b exp 0", imem_req); else passes++;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 11'h000)
            $display("FAIL reset_req_rise: got req=%b addr=%h exp req=1 addr=000", imem_req, imem_addr); else passes++;
        exp_pc = 11'h000; exp_ret = 16'h0000;
    endtask

    task automatic test_basic();
        logic [10:0] a; logic r; logic [15:0] ins; logic iok, q, we; logic [1:0] s;
        apply_reset();
        run_instr(16'h1234, 2, 0, 0, 2'b00, 11'h001, 1'b0, a, r, ins, iok, q, s, we);
        checks++; if (a !== 11'h000 || r !== 1'b1) $display("FAIL basic_fetch: got addr=%h req=%b exp 000/1", a, r); else passes++;
        checks++; if (ins !== 16'h1234) $display("FAIL basic_instr: got %h exp 1234", ins); else passes++;
        checks++; if (q !== 1'b1) $display("FAIL basic_quiet: got %b exp 1", q); else passes++;
        checks++; if (s !== 2'b00 || we !== 1'b1) $display("FAIL basic_resolve: got src=%b we=%b exp 00/1", s, we); else passes++;
        checks++; if (pc !== 11'h001 || retire_cnt !== 16'd1)
            $display("FAIL basic_retire: got pc=%h cnt=%0d exp 001/1", pc, retire_cnt); else passes++;
        exp_pc = 11'h001; exp_ret = 16'd1;
    endtask

    task automatic test_wrap();
        logic [10:0] a; logic r; logic [15:0] ins; logic iok, q, we; logic [1:0] s;
        run_instr(16'hA001, 1, 1, 1, 2'b10, 11'h7FF, 1'b0, a, r, ins, iok, q, s, we);
        exp_pc = 11'h7FF; exp_ret = exp_ret + 16'd1;
        checks++; if (imem_addr !== exp_pc) $display("FAIL wrap_setup: got %h exp %h", imem_addr, exp_pc); else passes++;
        run_instr(16'hA002, 0, 0, 0, 2'b00, 11'h000, 1'b0, a, r, ins, iok, q, s, we);
        exp_pc = 11'h000; exp_ret = exp_ret + 16'd1;
        checks++; if (a !== 11'h7FF) $display("FAIL wrap_addr: got %h exp 7ff", a); else passes++;
        checks++; if (pc !== exp_pc || retire_cnt !== exp_ret)
            $display("FAIL wrap_pc: got pc=%h cnt=%0d exp %h/%0d", pc, retire_cnt, exp_pc, exp_ret); else passes++;
    endtask

    task automatic test_jal();
        logic [10:0] a; logic r; logic [15:0] ins; logic iok, q, we; logic [1:0] s;
        run_instr(16'h5A5A, 0, 0, 2, 2'b11, 11'h2A5, 1'b0, a, r, ins, iok, q, s, we);
        exp_pc = 11'h2A5; exp_ret = exp_ret + 16'd1;
        checks++; if (s !== 2'b11 || we !== 1'b1) $display("FAIL jal_resolve: got src=%b we=%b exp 11/1", s, we); else passes++;
        checks++; if (q !== 1'b1) $display("FAIL jal_quiet: got %b exp 1", q); else passes++;
        checks++; if (imem_addr !== 11'h2A5 || imem_req !== 1'b1)
            $display("FAIL jal_next_fetch: got addr=%h req=%b exp 2a5/1", imem_addr, imem_req); else passes++;
    endtask

    task automatic test_stall();
        logic [10:0] a; logic r; logic [15:0] ins; logic iok, q, we; logic [1:0] s;
        run_instr(16'hC3C3, 0, 5, 0, 2'b01, 11'h123, 1'b0, a, r, ins, iok, q, s, we);
        exp_pc = 11'h123; exp_ret = exp_ret + 16'd1;
        checks++; if (iok !== 1'b1) $display("FAIL stall_issue_hold: got %b exp 1", iok); else passes++;
        checks++; if (ins !== 16'hC3C3) $display("FAIL stall_instr: got %h exp c3c3", ins); else passes++;
        checks++; if (pc !== exp_pc || retire_cnt !== exp_ret)
            $display("FAIL stall_retire: got pc=%h cnt=%0d exp %h/%0d", pc, retire_cnt, exp_pc, exp_ret); else passes++;
    endtask

    task automatic test_random();
        logic [10:0] a; logic r; logic [15:0] ins; logic iok, q, we; logic [1:0] s;
        logic [15:0] rd; logic [1:0] src; logic [10:0] npc;
        for (int n = 0; n < 40; n++) begin
            rd = 16'($urandom); src = 2'($urandom); npc = 11'($urandom);
            run_instr(rd, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      src, npc, 1'b0, a, r, ins, iok, q, s, we);
            checks++;
            if (a !== exp_pc || ins !== rd || s !== src || we !== 1'b1 || iok !== 1'b1 || q !== 1'b1)
                $display("FAIL rand_txn%0d: got addr=%h instr=%h src=%b we=%b ok=%b%b exp %h/%h/%b/1/11",
                         n, a, ins, s, we, iok, q, exp_pc, rd, src);
            else passes++;
            exp_pc = npc; exp_ret = exp_ret + 16'd1;
            checks++;
            if (pc !== exp_pc || retire_cnt !== exp_ret)
                $display("FAIL rand_state%0d: got pc=%h cnt=%0d exp %h/%0d", n, pc, retire_cnt, exp_pc, exp_ret);
            else passes++;
        end
    endtask

    task automatic test_mid_fetch_reset();
        step();
        checks++; if (imem_req !== 1'b1) $display("FAIL midrst_pre_req: got %b exp 1", imem_req); else passes++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        step();
        imem_ack = 1'b0;
        exp_pc = 11'h000; exp_ret = 16'h0000;
        checks++; if (instr !== 16'h0000 || instr_valid !== 1'b0)
            $display("FAIL midrst_ack_ignored: got instr=%h valid=%b exp 0000/0", instr, instr_valid); else passes++;
        checks++; if (pc !== 11'h000 || retire_cnt !== 16'h0000 || imem_req !== 1'b1)
            $display("FAIL midrst_state: got pc=%h cnt=%0d req=%b exp 000/0/1", pc, retire_cnt, imem_req); else passes++;
    endtask

    task automatic test_halt();
        logic [10:0] a; logic r; logic [15:0] ins; logic iok, q, we; logic [1:0] s;
        logic bad;
        run_instr(16'h0F0F, 1, 1, 3, 2'b01, 11'h010, 1'b1, a, r, ins, iok, q, s, we);
        exp_pc = 11'h010; exp_ret = exp_ret + 16'd1;
        checks++; if (we !== 1'b1 || q !== 1'b1) $display("FAIL halt_resolve: got we=%b quiet=%b exp 1/1", we, q); else passes++;
        checks++; if (pc !== 11'h010 || halted !== 1'b1 || retire_cnt !== exp_ret)
            $display("FAIL halt_state: got pc=%h halted=%b cnt=%0d exp 010/1/%0d", pc, halted, retire_cnt, exp_ret); else passes++;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'($urandom); instr_ready = 1'($urandom); resolve_valid = 1'($urandom);
            next_pc = 11'($urandom);
            #1;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_we !== 1'b0 || halted !== 1'b1) bad = 1'b1;
            step();
        end
        imem_ack = 1'b0; instr_ready = 1'b0; resolve_valid = 1'b0;
        checks++; if (bad !== 1'b0 || pc !== exp_pc || retire_cnt !== exp_ret)
            $display("FAIL halt_sticky: got bad=%b pc=%h cnt=%0d exp 0/%h/%0d", bad, pc, retire_cnt, exp_pc, exp_ret); else passes++;
        apply_reset();
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || pc !== 11'h000)
            $display("FAIL halt_exit_reset: got halted=%b req=%b pc=%h exp 0/1/000", halted, imem_req, pc); else passes++;
    endtask

    task automatic test_fetch_wait();
        apply_reset();
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < int'(TO_CYCLES) - 1; i++) step();
        checks++; if (fetch_err !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL to_before: got err=%b halted=%b req=%b exp 0/0/1", fetch_err, halted, imem_req); else passes++;
        step();
        checks++; if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL to_expire: got err=%b halted=%b req=%b exp 1/1/0", fetch_err, halted, imem_req); else passes++;
        apply_reset();
        checks++; if (fetch_err !== 1'b0) $display("FAIL to_reset_clear: got %b exp 0", fetch_err); else passes++;
        for (int i = 0; i < int'(TO_CYCLES) - 1; i++) step();
        imem_ack = 1'b1; imem_rdata = 16'h7E57;
        step();
        imem_ack = 1'b0;
        checks++; if (fetch_err !== 1'b0 || instr_valid !== 1'b1 || instr !== 16'h7E57)
            $display("FAIL to_ack_wins: got err=%b valid=%b instr=%h exp 0/1/7e57", fetch_err, instr_valid, instr); else passes++;
        apply_reset();
`else
        for (int i = 0; i < 40; i++) step();
        checks++; if (fetch_err !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 11'h000)
            $display("FAIL wait_forever: got err=%b halted=%b req=%b addr=%h exp 0/0/1/000",
                     fetch_err, halted, imem_req, imem_addr); else passes++;
        imem_ack = 1'b1; imem_rdata = 16'h4321;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h4321)
            $display("FAIL wait_late_ack: got valid=%b instr=%h exp 1/4321", instr_valid, instr); else passes++;
        apply_reset();
`endif
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        resolve_valid = 1'b0; resolve_src = 2'b00; halt = 1'b0; next_pc = '0;
        exp_pc = '0; exp_ret = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_jal();
        test_stall();
        test_random();
        test_mid_fetch_reset();
        test_random();
        test_halt();
        test_fetch_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
